// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and constants for the HI/LO multiply/divide control.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] HILO_WE_HI = 2'b10;
    localparam logic [1:0] HILO_WE_LO = 2'b01;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_watchdog
// Purpose  : Busy-cycle counter; flags the cycle whose edge reaches TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_watchdog #(
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Terminal one cycle early so the abort lands exactly after TIMEOUT busy cycles.
    assign term_o = en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : Issue/sequencing control for the multi-cycle MU/DU and HI/LO write.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        mul_start,
    output logic        div_start,
    output logic        unit_signed,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        mul_done,
    input  logic [63:0] mul_result,
    input  logic        div_done,
    input  logic [63:0] div_result,
    output logic        stall,
    output logic [1:0]  hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        busy,
    output logic        timeout_err
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [63:0] res_q, res_d;
    logic        wr_q, wr_d;
    logic        start_q, start_d;
    logic        div_unit_q, div_unit_d;
    logic        err_q, err_d;

    logic        w_op_ok;
    logic        w_unit_done;
    logic [63:0] w_unit_result;
    logic        w_wd_clr;
    logic        w_wd_en;
    logic        w_wd_term;

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_wd_clr),
        .en_i   (w_wd_en),
        .term_o (w_wd_term)
    );

    assign w_op_ok       = op_valid && !flush;
    assign w_unit_done   = div_unit_q ? div_done : mul_done;
    assign w_unit_result = div_unit_q ? div_result : mul_result;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        res_d      = res_q;
        wr_d       = wr_q;
        start_d    = 1'b0;
        div_unit_d = div_unit_q;
        err_d      = err_q;
        w_wd_clr   = 1'b0;
        w_wd_en    = 1'b0;
        stall      = 1'b0;
        hilo_we    = 2'b00;
        hi_wdata   = src_a;
        lo_wdata   = src_a;

        case (state_q)
            ST_IDLE: begin
                if (w_op_ok && (is_mul_op(op_code) || is_div_op(op_code))) begin
                    stall      = 1'b1;
                    a_d        = src_a;
                    b_d        = src_b;
                    sgn_d      = (op_code == OP_MULT) || (op_code == OP_DIV);
                    div_unit_d = is_div_op(op_code);
                    if (is_div_op(op_code) && (src_b == 32'd0)) begin
                        // Divide by zero never reaches the DU; HI/LO stay untouched.
                        wr_d    = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        wr_d     = 1'b1;
                        start_d  = 1'b1;
                        w_wd_clr = 1'b1;
                        state_d  = is_div_op(op_code) ? ST_DIV : ST_MUL;
                    end
                end else if (w_op_ok && (op_code == OP_MTHI)) begin
                    hilo_we = HILO_WE_HI;
                end else if (w_op_ok && (op_code == OP_MTLO)) begin
                    hilo_we = HILO_WE_LO;
                end
            end

            ST_MUL, ST_DIV: begin
                stall   = 1'b1;
                w_wd_en = 1'b1;
                if (w_unit_done) begin
                    res_d   = w_unit_result;
                    // A flush coinciding with completion has nothing left to drain.
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    w_wd_clr = 1'b1;
                    state_d  = ST_DRAIN;
                end else if (w_wd_term) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                hi_wdata = res_q[63:32];
                lo_wdata = res_q[31:0];
                if (wr_q && !flush) begin
                    hilo_we = HILO_WE_HI | HILO_WE_LO;
                end
                state_d = ST_IDLE;
            end

            ST_DRAIN: begin
                w_wd_en = 1'b1;
                stall   = w_op_ok && (is_mul_op(op_code) || is_div_op(op_code));
                if (w_op_ok && (op_code == OP_MTHI)) begin
                    hilo_we = HILO_WE_HI;
                end else if (w_op_ok && (op_code == OP_MTLO)) begin
                    hilo_we = HILO_WE_LO;
                end
                if (w_unit_done) begin
                    state_d = ST_IDLE;
                end else if (w_wd_term) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            res_q      <= '0;
            wr_q       <= 1'b0;
            start_q    <= 1'b0;
            div_unit_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            res_q      <= res_d;
            wr_q       <= wr_d;
            start_q    <= start_d;
            div_unit_q <= div_unit_d;
            err_q      <= err_d;
        end
    end

    assign mul_start   = start_q && (state_q == ST_MUL);
    assign div_start   = start_q && (state_q == ST_DIV);
    assign unit_signed = sgn_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_ctrl
// Purpose  : Self-checking bench; the bench also plays the MU and DU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        mul_start, div_start, unit_signed;
    logic [31:0] unit_a, unit_b;
    logic        mul_done, div_done;
    logic [63:0] mul_result, div_result;
    logic        stall;
    logic [1:0]  hilo_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        busy, timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .mul_start(mul_start), .div_start(div_start), .unit_signed(unit_signed),
        .unit_a(unit_a), .unit_b(unit_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .div_done(div_done), .div_result(div_result),
        .stall(stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic settle(); @(negedge clk); endtask
    task automatic adv();    @(posedge clk); #1; endtask

    task automatic idle_inputs();
        op_valid = 1'b0; op_code = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        mul_done = 1'b0; div_done = 1'b0; mul_result = '0; div_result = '0;
    endtask

    // Architectural result: MU gives {hi,lo} product, DU gives {remainder,quotient}.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub;
        int          ia, ib;
        logic [31:0] q, r;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        ia = a; ib = b;
        q = '0; r = '0;
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV:   begin q = 32'(ia / ib); r = 32'(ia % ib); return {r, q}; end
            OP_DIVU:  begin q = a / b; r = a % b; return {r, q}; end
            default:  return 64'd0;
        endcase
    endfunction

    // Issue one MU/DU op from IDLE; its done arrives in the d-th unit cycle.
    task automatic run_unit_op(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int d);
        logic [63:0] exp;
        logic        is_div, sgn;
        int          stalls, starts, wrong_starts, opnd_bad, early_wr;
        exp = ref_result(op, a, b);
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        sgn = (op == OP_MULT) || (op == OP_DIV);
        stalls = 0; starts = 0; wrong_starts = 0; opnd_bad = 0; early_wr = 0;
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b; flush = 1'b0;
        settle();
        n_checks++;
        if (stall !== 1'b1) $display("FAIL accept_stall op=%0d: got %b want 1", op, stall);
        else n_pass++;
        if (stall === 1'b1) stalls++;
        adv();
        for (int i = 1; i <= d; i++) begin
            if (i == d) begin
                if (is_div) begin div_done = 1'b1; div_result = exp; end
                else        begin mul_done = 1'b1; mul_result = exp; end
            end else if (i == 1) begin
                if (is_div) begin mul_done = 1'b1; mul_result = ~exp; end
                else        begin div_done = 1'b1; div_result = ~exp; end
            end
            settle();
            if (stall === 1'b1) stalls++;
            if ((is_div ? div_start : mul_start) === 1'b1) starts++;
            if ((is_div ? mul_start : div_start) !== 1'b0) wrong_starts++;
            if (unit_a !== a || unit_b !== b || unit_signed !== sgn) opnd_bad++;
            if (hilo_we !== 2'b00) early_wr++;
            adv();
            mul_done = 1'b0; div_done = 1'b0;
        end
        settle();
        n_checks++;
        if (stall !== 1'b0 || hilo_we !== 2'b11)
            $display("FAIL done_write op=%0d: got stall=%b we=%b want stall=0 we=11", op, stall, hilo_we);
        else n_pass++;
        n_checks++;
        if (hi_wdata !== exp[63:32] || lo_wdata !== exp[31:0])
            $display("FAIL done_data op=%0d a=%h b=%h: got %h_%h want %h_%h",
                     op, a, b, hi_wdata, lo_wdata, exp[63:32], exp[31:0]);
        else n_pass++;
        adv();
        op_valid = 1'b0;
        n_checks++;
        if (stalls != d + 1) $display("FAIL stall_len op=%0d: got %0d want %0d", op, stalls, d + 1);
        else n_pass++;
        n_checks++;
        if (starts != 1 || wrong_starts != 0)
            $display("FAIL start_pulse op=%0d: got %0d starts (%0d wrong) want 1 (0)", op, starts, wrong_starts);
        else n_pass++;
        n_checks++;
        if (opnd_bad != 0 || early_wr != 0)
            $display("FAIL operands op=%0d: got %0d bad operand cycles, %0d early writes want 0", op, opnd_bad, early_wr);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        adv(); adv();
        rst = 1'b0;
        settle();
        n_checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || hilo_we !== 2'b00 || timeout_err !== 1'b0)
            $display("FAIL reset_ctl: got busy=%b stall=%b we=%b err=%b want 0 0 00 0", busy, stall, hilo_we, timeout_err);
        else n_pass++;
        n_checks++;
        if (mul_start !== 1'b0 || div_start !== 1'b0 || unit_a !== 32'd0 || unit_b !== 32'd0 || unit_signed !== 1'b0)
            $display("FAIL reset_unit: got ms=%b ds=%b a=%h b=%h s=%b want all 0", mul_start, div_start, unit_a, unit_b, unit_signed);
        else n_pass++;
        adv();
    endtask

    task automatic test_mult();
        logic [2:0] op;
        run_unit_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 4);
        for (int k = 0; k < 6; k++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
            run_unit_op(op, $urandom, $urandom, $urandom_range(1, 8));
        end
    endtask

    task automatic test_div();
        logic [2:0]  op;
        logic [31:0] a, b;
        run_unit_op(OP_DIVU, 32'd100, 32'd7, 8);
        for (int k = 0; k < 6; k++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a = $urandom; b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            run_unit_op(op, a, b, $urandom_range(1, 10));
        end
    endtask

    task automatic test_div_zero();
        op_valid = 1'b1; op_code = OP_DIV; src_a = $urandom; src_b = 32'd0;
        settle();
        n_checks++;
        if (stall !== 1'b1 || div_start !== 1'b0)
            $display("FAIL divz_accept: got stall=%b ds=%b want 1 0", stall, div_start);
        else n_pass++;
        adv();
        settle();
        n_checks++;
        if (stall !== 1'b0 || hilo_we !== 2'b00 || div_start !== 1'b0)
            $display("FAIL divz_done: got stall=%b we=%b ds=%b want 0 00 0", stall, hilo_we, div_start);
        else n_pass++;
        adv();
        op_valid = 1'b0;
        settle();
        n_checks++;
        if (busy !== 1'b0 || hilo_we !== 2'b00)
            $display("FAIL divz_idle: got busy=%b we=%b want 0 00", busy, hilo_we);
        else n_pass++;
        adv();
    endtask

    task automatic test_flush_drain();
        logic [31:0] mv, a2, b2;
        int          bad;
        mv = $urandom; a2 = $urandom; b2 = $urandom; bad = 0;
        op_valid = 1'b1; op_code = OP_MULT; src_a = $urandom; src_b = $urandom;
        settle(); adv();
        flush = 1'b1;
        settle();
        n_checks++;
        if (mul_start !== 1'b1 || stall !== 1'b1)
            $display("FAIL flush_cycle: got ms=%b stall=%b want 1 1", mul_start, stall);
        else n_pass++;
        adv();
        flush = 1'b0; op_code = OP_MTHI; src_a = mv;
        settle();
        n_checks++;
        if (stall !== 1'b0 || hilo_we !== 2'b10 || hi_wdata !== mv)
            $display("FAIL drain_mthi: got stall=%b we=%b hi=%h want 0 10 %h", stall, hilo_we, hi_wdata, mv);
        else n_pass++;
        adv();
        op_code = OP_MULT; src_a = a2; src_b = b2;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (stall !== 1'b1 || mul_start !== 1'b0 || hilo_we !== 2'b00) bad++;
            adv();
        end
        n_checks++;
        if (bad != 0) $display("FAIL drain_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        mul_done = 1'b1; mul_result = 64'hDEAD_BEEF_0BAD_F00D;
        settle();
        n_checks++;
        if (stall !== 1'b1 || hilo_we !== 2'b00)
            $display("FAIL drain_discard: got stall=%b we=%b want 1 00", stall, hilo_we);
        else n_pass++;
        adv();
        mul_done = 1'b0;
        run_unit_op(OP_MULT, a2, b2, 3);
    endtask

    task automatic test_done_flush();
        op_valid = 1'b1; op_code = OP_MULTU; src_a = $urandom; src_b = $urandom;
        settle(); adv();
        mul_done = 1'b1; mul_result = {src_a, src_b};
        settle(); adv();
        mul_done = 1'b0; flush = 1'b1;
        settle();
        n_checks++;
        if (stall !== 1'b0 || hilo_we !== 2'b00)
            $display("FAIL done_flush: got stall=%b we=%b want 0 00", stall, hilo_we);
        else n_pass++;
        adv();
        idle_inputs();
    endtask

    task automatic test_timeout();
        int  busy_cycles, writes;
        bit  stop;
        busy_cycles = 0; writes = 0; stop = 1'b0;
        op_valid = 1'b1; op_code = OP_DIV; src_a = $urandom; src_b = $urandom | 32'd1;
        settle(); adv();
        while (!stop) begin
            settle();
            if (busy !== 1'b1) stop = 1'b1;
            else begin
                busy_cycles++;
                if (hilo_we !== 2'b00) writes++;
                if (busy_cycles > 200) stop = 1'b1;
                else adv();
            end
        end
        op_valid = 1'b0;
        #1;
        n_checks++;
        if (busy_cycles != TIMEOUT) $display("FAIL timeout_len: got %0d want %0d", busy_cycles, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (timeout_err !== 1'b1 || stall !== 1'b0 || busy !== 1'b0 || writes != 0)
            $display("FAIL timeout_state: got err=%b stall=%b busy=%b writes=%0d want 1 0 0 0",
                     timeout_err, stall, busy, writes);
        else n_pass++;
        adv();
        run_unit_op(OP_MULTU, $urandom, $urandom, 2);
        n_checks++;
        if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        v = $urandom;
        op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'h1234; flush = 1'b0;
        settle();
        n_checks++;
        if (hilo_we !== 2'b10 || hi_wdata !== 32'h1234 || stall !== 1'b0)
            $display("FAIL mthi: got we=%b hi=%h stall=%b want 10 00001234 0", hilo_we, hi_wdata, stall);
        else n_pass++;
        adv();
        flush = 1'b1;
        settle();
        n_checks++;
        if (hilo_we !== 2'b00) $display("FAIL mthi_flush: got we=%b want 00", hilo_we);
        else n_pass++;
        adv();
        flush = 1'b0; op_code = OP_MTLO; src_a = v;
        settle();
        n_checks++;
        if (hilo_we !== 2'b01 || lo_wdata !== v || stall !== 1'b0)
            $display("FAIL mtlo: got we=%b lo=%h stall=%b want 01 %h 0", hilo_we, lo_wdata, stall, v);
        else n_pass++;
        adv();
        idle_inputs();
    endtask

    task automatic test_reset_midop();
        op_valid = 1'b1; op_code = OP_MULT; src_a = $urandom; src_b = $urandom;
        settle(); adv();
        rst = 1'b1;
        adv();
        rst = 1'b0; op_valid = 1'b0;
        mul_done = 1'b1; mul_result = 64'h1111_2222_3333_4444;
        settle();
        n_checks++;
        if (busy !== 1'b0 || hilo_we !== 2'b00 || stall !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL reset_midop: got busy=%b we=%b stall=%b err=%b want 0 00 0 0",
                     busy, hilo_we, stall, timeout_err);
        else n_pass++;
        adv();
        mul_done = 1'b0;
        settle();
        n_checks++;
        if (hilo_we !== 2'b00 || busy !== 1'b0)
            $display("FAIL reset_late_done: got we=%b busy=%b want 00 0", hilo_we, busy);
        else n_pass++;
        adv();
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_flush_drain();
        test_done_flush();
        test_mthi_mtlo();
        test_timeout();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Issue/sequencing controller for the multi-cycle multiply (MU) and divide (DU) units in the EX stage. It accepts one HI/LO-class instruction per cycle from EX and holds the pipeline while a unit is busy. It routes the completed 64-bit result into the HI/LO write port, discards results of flushed instructions, and flags a unit that never completes.

Parameters:
TIMEOUT, 63, max cycles in a busy/drain state before abort
CNT_W, 6, width of the watchdog counter (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid  in  1  EX holds a HI/LO-class op this cycle
op_code  in  3  MULT/MULTU/DIV/DIVU/MTHI/MTLO (package enum)
src_a  in  32  forwarded rs value
src_b  in  32  forwarded rt value
flush  in  1  kill the instruction currently in EX
mul_start  out  1  one-cycle start pulse to MU
div_start  out  1  one-cycle start pulse to DU
unit_signed  out  1  signed operation (MULT/DIV)
unit_a  out  32  latched operand A
unit_b  out  32  latched operand B
mul_done  in  1  MU result valid
mul_result  in  64  {hi,lo} product
div_done  in  1  DU result valid
div_result  in  64  {remainder,quotient}
stall  out  1  hold IF/ID/EX this cycle
hilo_we  out  2  [1]=HI write, [0]=LO write
hi_wdata  out  32  HI write data
lo_wdata  out  32  LO write data
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock port is clk; reset port is rst, synchronous, active-high. Single clock domain.
- Reset: state=IDLE, counter=0, all registered outputs 0, timeout_err=0. Reset mid-operation aborts with no HI/LO write; a later unit done is ignored.
- States: IDLE, MUL, DIV, DONE, DRAIN.
- IDLE, op_valid & ~flush & MULT/MULTU:
  - latch src_a/src_b and signedness; next state MUL.
  - stall=1 combinationally in the acceptance cycle.
  - mul_start=1 for exactly the first MUL cycle.
- IDLE, DIV/DIVU: same as MULT, using DIV and div_start.
- DIV/DIVU with src_b==0: no div_start; next state DONE with the write suppressed (HI/LO unchanged). Total stall = 1 cycle.
- IDLE, MTHI/MTLO & ~flush: combinational write in the same cycle; hilo_we=10 (MTHI) or 01 (MTLO); data=src_a; no stall.
- IDLE with flush, or with op_valid=0: nothing happens.
- MUL/DIV:
  - stall=1; counter increments each cycle.
  - the matching done (accepted from the first MUL/DIV cycle on) latches the result; next state DONE.
  - done from the other unit is ignored.
- DONE:
  - stall=0 so EX advances at this edge.
  - hilo_we=11 & ~flush, with hi/lo data from the latched result.
  - next state IDLE.
  - A new op is not accepted in DONE.
- flush in MUL/DIV: next state DRAIN; stall=0 from the next cycle.
- DRAIN:
  - waits for the outstanding done, discards the result, then returns to IDLE.
  - a new MULT/DIV presented in DRAIN stalls (stall=1) until IDLE and is then accepted normally.
  - MTHI/MTLO in DRAIN proceeds without stall.
- Watchdog: when counter reaches TIMEOUT in MUL/DIV/DRAIN:
  - timeout_err<=1 (sticky until rst);
  - next state IDLE, no write, stall released.
- Counter clears on every entry to MUL/DIV/DRAIN.
- unit_a, unit_b and unit_signed are held stable from acceptance until leaving MUL/DIV.
- Spurious done in IDLE or DONE is ignored.

Decomposition:
- Package muldiv_pkg: op_code enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5); state enum; HILO_WE_HI/LO constants.
- Sub-module muldiv_watchdog: counter with clear/enable and a terminal flag.

Test Plan:
1. MULT a=-3, b=5; mul_done 4 cycles after mul_start with result 64'hFFFFFFFF_FFFFFFF1 -> mul_start pulsed once; stall high 5 cycles; DONE gives hilo_we=11, hi=FFFFFFFF, lo=FFFFFFF1.
2. DIVU 100/7; div_done after 8 cycles with {2,14} -> unit_signed=0; hi=2, lo=14 in DONE.
3. DIV b=0 -> no div_start; stall exactly 1 cycle; hilo_we stays 00.
4. MULT accepted, flush on cycle 2 -> stall=0 from cycle 3; a new MULT on cycle 4 stalls until the old mul_done, then issues its own mul_start; only the second result is written.
5. DIV with div_done never asserted -> after 63 busy cycles timeout_err=1, state IDLE, stall=0, no write.
6. MTHI src_a=32'h1234, flush=0 -> hilo_we=10, hi_wdata=1234, stall=0; repeat with flush=1 -> hilo_we=00.
